// File: rtl/mmr_pkg.sv
// Shared types and constants for the MMR AXI4-Lite initiator.
// Bus widths for the MMR fabric live here alongside the FSM encoding.
package mmr_pkg;

  localparam int MMR_DEV_ADDR_W = 16;
  localparam int MMR_DATA_W     = 32;
  localparam int MMR_STRB_W     = MMR_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } mmr_master_state_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle between MMR initiators and slaves.
// m = initiator side, s = slave side.
interface axi4_lite_if;
  import mmr_pkg::*;

  logic [MMR_DEV_ADDR_W-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;

  logic [MMR_DATA_W-1:0]     wdata;
  logic [MMR_STRB_W-1:0]     wstrb;
  logic                      wvalid;
  logic                      wready;

  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [MMR_DEV_ADDR_W-1:0] araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;

  logic [MMR_DATA_W-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport m (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport s (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/mmr_master.sv
// Single-beat AXI4-Lite initiator for MMR register commands.
// Every transaction ends in one rsp_valid pulse, OKAY/ERR or timeout.
module mmr_master
  import mmr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      app_clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [MMR_DEV_ADDR_W-1:0] cmd_addr,
  input  logic [MMR_DATA_W-1:0]     cmd_wdata,
  input  logic [MMR_STRB_W-1:0]     cmd_wstrb,
  output logic                      rsp_valid,
  output logic [MMR_DATA_W-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  axi4_lite_if.m                    mmr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  mmr_master_state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MMR_DEV_ADDR_W-1:0] addr_q, addr_d;
  logic [MMR_DATA_W-1:0]     wdata_q, wdata_d;
  logic [MMR_STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;

  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [MMR_DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic expired;
  logic go_done, go_tmo;
  logic [MMR_DATA_W-1:0] cap_data;
  logic [1:0]            cap_resp;

  assign ar_hs   = arvalid_q & mmr.arready;
  assign r_hs    = rready_q  & mmr.rvalid;
  assign aw_hs   = awvalid_q & mmr.awready;
  assign w_hs    = wvalid_q  & mmr.wready;
  assign b_hs    = bready_q  & mmr.bvalid;
  assign expired = (cnt_q == CNT_MAX);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    go_done       = 1'b0;
    go_tmo        = 1'b0;
    cap_data      = '0;
    cap_resp      = RESP_OKAY;

    if (state_q != IDLE && state_q != DONE) begin
      cnt_d = expired ? cnt_q : cnt_q + 1'b1;
    end

    // A handshake at the expiry edge always beats the timeout.
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        if (ar_hs && r_hs) begin
          go_done  = 1'b1;
          cap_data = mmr.rdata;
          cap_resp = mmr.rresp;
        end else if (ar_hs) begin
          state_d = RD_D;
        end else if (expired) begin
          go_tmo = 1'b1;
        end
      end
      RD_D: begin
        if (r_hs) begin
          go_done  = 1'b1;
          cap_data = mmr.rdata;
          cap_resp = mmr.rresp;
        end else if (expired) begin
          go_tmo = 1'b1;
        end
      end
      WR_AW: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WR_B;
        end else if (expired) begin
          go_tmo = 1'b1;
        end
      end
      WR_B: begin
        if (b_hs) begin
          go_done  = 1'b1;
          cap_resp = mmr.bresp;
        end else if (expired) begin
          go_tmo = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_tmo) begin
      state_d       = DONE;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
    end else if (go_done) begin
      state_d       = DONE;
      rsp_rdata_d   = cap_data;
      rsp_resp_d    = cap_resp;
      rsp_timeout_d = 1'b0;
    end

    // Outputs are decoded from the next state so they leave the flops aligned.
    cmd_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == RD_A);
    rready_d    = (state_d == RD_A) || (state_d == RD_D);
    awvalid_d   = (state_d == WR_AW) && !aw_done_d;
    wvalid_d    = (state_d == WR_AW) && !w_done_d;
    bready_d    = (state_d == WR_AW) || (state_d == WR_B);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge app_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign mmr.araddr  = addr_q;
  assign mmr.arprot  = 3'b000;
  assign mmr.arvalid = arvalid_q;
  assign mmr.rready  = rready_q;
  assign mmr.awaddr  = addr_q;
  assign mmr.awprot  = 3'b000;
  assign mmr.awvalid = awvalid_q;
  assign mmr.wdata   = wdata_q;
  assign mmr.wstrb   = wstrb_q;
  assign mmr.wvalid  = wvalid_q;
  assign mmr.bready  = bready_q;

endmodule

// File: tb/tb_mmr_master.sv
// Scoreboard bench for mmr_master against a configurable AXI4-Lite
// register slave with stall, fast-read and stuck-response modes.
module tb_mmr_master;
  import mmr_pkg::*;

  localparam int TO = 16;

  logic app_clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [MMR_DEV_ADDR_W-1:0] cmd_addr;
  logic [MMR_DATA_W-1:0]     cmd_wdata;
  logic [MMR_STRB_W-1:0]     cmd_wstrb;
  logic rsp_valid, rsp_timeout;
  logic [MMR_DATA_W-1:0] rsp_rdata;
  logic [1:0] rsp_resp;

  axi4_lite_if bus ();

  mmr_master #(.TIMEOUT_CYCLES(TO)) dut (
    .app_clk     (app_clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .mmr         (bus)
  );

  always #5 app_clk = ~app_clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rsp_cyc = 0;
  int acc_cyc = 0;
  int n_rsp = 0;
  logic [31:0] ref_mem [64];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge app_clk) cyc <= cyc + 1;

  // slave knobs
  logic ar_en = 1'b1;
  logic r_fast = 1'b0;
  logic b_en = 1'b1;
  int aw_hold = 0;

  logic [31:0] mem [64];
  logic aw_got, w_got;
  logic [MMR_DEV_ADDR_W-1:0] wa;
  logic [31:0] wd;
  logic [3:0] ws;
  int aw_wait;

  always @(posedge app_clk) begin
    if (rst) begin
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_wait     <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.arready <= 1'b0;
        if (!r_fast) begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= mem[bus.araddr[7:2]];
        end
      end else if (bus.arvalid && !bus.arready && !bus.rvalid && ar_en) begin
        bus.arready <= 1'b1;
        if (r_fast) begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= mem[bus.araddr[7:2]];
        end
      end
      if (bus.awvalid && bus.awready) begin
        aw_got      <= 1'b1;
        wa          <= bus.awaddr;
        bus.awready <= 1'b0;
        aw_wait     <= 0;
      end else if (bus.awvalid && !aw_got && !bus.awready) begin
        if (aw_wait >= aw_hold) bus.awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (bus.wvalid && bus.wready) begin
        w_got      <= 1'b1;
        wd         <= bus.wdata;
        ws         <= bus.wstrb;
        bus.wready <= 1'b0;
      end else if (bus.wvalid && !w_got && !bus.wready) begin
        bus.wready <= 1'b1;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else if (aw_got && w_got && !bus.bvalid && b_en) begin
        for (int i = 0; i < 4; i++)
          if (ws[i]) mem[wa[7:2]][i*8 +: 8] <= wd[i*8 +: 8];
        bus.bvalid <= 1'b1;
      end
    end
  end

  // channel transfer counters and early-drop detection
  int aw_xfer = 0, w_xfer = 0, aw_early = 0, w_early = 0;
  logic aw_hs_last = 1'b0, w_hs_last = 1'b0;
  logic aw_prev = 1'b0, w_prev = 1'b0;

  always @(posedge app_clk) begin
    aw_hs_last <= bus.awvalid && bus.awready;
    w_hs_last  <= bus.wvalid && bus.wready;
    if (bus.awvalid && bus.awready) aw_xfer <= aw_xfer + 1;
    if (bus.wvalid && bus.wready) w_xfer <= w_xfer + 1;
  end

  always @(negedge app_clk) begin
    if (aw_prev && !bus.awvalid && !aw_hs_last) aw_early <= aw_early + 1;
    if (w_prev && !bus.wvalid && !w_hs_last) w_early <= w_early + 1;
    aw_prev <= bus.awvalid;
    w_prev  <= bus.wvalid;
  end

  always @(negedge app_clk) begin
    if (rsp_valid) begin
      rsp_cyc = cyc;
      n_rsp++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_resp", rsp_resp, mon_e.resp);
        chk("rsp_timeout", rsp_timeout, mon_e.tmo);
      end
    end
  end

  int last_gap = 0;

  task automatic issue(input logic w, input logic [MMR_DEV_ADDR_W-1:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic track, input logic exp_to);
    exp_t e;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    while (!cmd_ready && n < 200) begin
      @(negedge app_clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      if (exp_to) begin
        e = '{rdata: '0, resp: RESP_SLVERR, tmo: 1'b1};
      end else if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_mem[a[7:2]][i*8 +: 8] = d[i*8 +: 8];
        e = '{rdata: '0, resp: RESP_OKAY, tmo: 1'b0};
      end else begin
        e = '{rdata: ref_mem[a[7:2]], resp: RESP_OKAY, tmo: 1'b0};
      end
      sb.push_back(e);
    end
    @(posedge app_clk);
    #1;
    acc_cyc = cyc;
    last_gap = acc_cyc - rsp_cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge app_clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, w0, ae0, we0, n0, n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(negedge app_clk);

    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid}, 0);
    chk("rst_readies", {bus.rready, bus.bready}, 0);
    chk("rst_addr", {bus.araddr, bus.awaddr}, 0);
    chk("rst_wdata", {bus.wdata, bus.wstrb}, 0);

    rst = 1'b0;
    @(negedge app_clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    issue(1'b1, 16'h10, 32'h1, 4'hF, 1'b1, 1'b0);
    chk("prot_zero", {bus.arprot, bus.awprot}, 0);
    issue(1'b0, 16'h10, 32'h0, 4'hF, 1'b1, 1'b0);
    issue(1'b0, 16'h1C, 32'h0, 4'hF, 1'b1, 1'b0);
    issue(1'b1, 16'h14, 32'hAABBCCDD, 4'hF, 1'b1, 1'b0);
    issue(1'b1, 16'h14, 32'h11223344, 4'h5, 1'b1, 1'b0);
    issue(1'b0, 16'h14, 32'h0, 4'hF, 1'b1, 1'b0);
    wait_idle();

    r_fast = 1'b1;
    issue(1'b0, 16'h10, 32'h0, 4'hF, 1'b1, 1'b0);
    wait_idle();
    r_fast = 1'b0;

    a0 = aw_xfer;
    w0 = w_xfer;
    ae0 = aw_early;
    we0 = w_early;
    aw_hold = 3;
    issue(1'b1, 16'h18, 32'h5A5A_A5A5, 4'hF, 1'b1, 1'b0);
    wait_idle();
    aw_hold = 0;
    chk("aw_xfer_count", aw_xfer - a0, 1);
    chk("w_xfer_count", w_xfer - w0, 1);
    chk("awvalid_early_drop", aw_early - ae0, 0);
    chk("wvalid_early_drop", w_early - we0, 0);
    issue(1'b0, 16'h18, 32'h0, 4'hF, 1'b1, 1'b0);
    wait_idle();

    ar_en = 1'b0;
    n0 = n_rsp;
    issue(1'b0, 16'h10, 32'h0, 4'hF, 1'b1, 1'b1);
    n = 0;
    while (n_rsp == n0 && n < 100) begin
      @(negedge app_clk);
      n++;
    end
    chk("timeout_latency", rsp_cyc - acc_cyc, 17);
    @(negedge app_clk);
    chk("arvalid_after_timeout", {bus.arvalid, bus.rready}, 0);
    wait_idle();
    ar_en = 1'b1;
    issue(1'b0, 16'h10, 32'h0, 4'hF, 1'b1, 1'b0);
    wait_idle();

    b_en = 1'b0;
    n0 = n_rsp;
    issue(1'b1, 16'h20, 32'hDEAD, 4'hF, 1'b0, 1'b0);
    n = 0;
    while (!(bus.bready && !bus.awvalid && !bus.wvalid) && n < 50) begin
      @(negedge app_clk);
      n++;
    end
    chk("reach_wr_b", n < 50, 1);
    rst = 1'b1;
    @(negedge app_clk);
    chk("midrst_valids", {bus.arvalid, bus.awvalid, bus.wvalid}, 0);
    chk("midrst_readies", {bus.rready, bus.bready}, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    b_en = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    @(negedge app_clk);
    chk("cmd_ready_after_midrst", cmd_ready, 1);
    chk("midrst_no_rsp", n_rsp - n0, 0);

    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(k[0] == 1'b0, 16'h10, 32'(k), 4'hF, 1'b1, 1'b0);
      cmd_valid = 1'b1;
      if (k > 0) chk("b2b_gap", last_gap, 2);
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_rsp_count", n_rsp - n0, 4);

    repeat (3) @(negedge app_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
